serial_ripple_subtractor: RTL

Bit-serial ripple subtractor: computes Diff = A − B − Bin and borrow-out Bout, one bit per clock, LSB first. It shares a single full-subtractor cell and a borrow flip-flop across all bit positions. It is the inverse-operation companion to the combinational ripple-carry adder and sits behind a valid/ready handshake on both sides. It trades latency for area in the arithmetic datapath.

---
 rtl/serial_ripple_subtractor.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple subtractor: Diff = A - B - Bin (mod 2^WIDTH), Bout = borrow out.
// A single full-subtractor cell and one borrow flop are reused for every bit, LSB first.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1.
// Input side: in_ready is high only in IDLE. Output side: out_valid is high only in DONE.
// Diff/Bout are meaningful only while out_valid is high.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic           borrow;
    logic [CW-1:0]  cnt;

    logic           d_bit;
    logic           borrow_nxt;

    // Shared full-subtractor cell working on the current LSBs and the borrow flop.
    always_comb begin
        d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
        borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    end

    // Control FSM and datapath registers; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            Diff      <= '0;
            Bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow   <= Bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Diff   <= {d_bit, Diff[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_nxt;
                    if (cnt == LAST) begin
                        // Final bit: the borrow leaving the MSB is the result borrow.
                        Bout      <= borrow_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
